rld: RTL and testbench
======================

RLD -- requirements
Module: rld

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  begin decoding; sampled only in IDLE or DONE.
REQ-004 rle_addr  input  32  byte address of compressed stream; low 2 bits ignored.
REQ-005 rle_size  input  32  compressed length in bytes.
REQ-006 message_addr  input  32  byte address of decoded output; low 2 bits ignored.
REQ-007 message_size  output  32  number of decoded bytes written.
REQ-008 done  output  1  decode complete.
REQ-009 port_A_clk  output  1  memory clock, driven equal to clk.
REQ-010 port_A_addr  output  16  word-aligned byte address (low 2 bits always 0).
REQ-011 port_A_we  output  1  1 = write, 0 = read.
REQ-012 port_A_data_in  output  32  write data to memory.
REQ-013 port_A_data_out  input  32  read data from memory; valid one cycle after the read address is presented.

Function
REQ-014 Stream format: byte pairs (count, symbol), count first; bytes packed little-endian in words (byte0 = bits [7:0]).
REQ-015 Each pair expands to count copies of symbol; count range 0..255; count 0 produces no output.
REQ-016 Decoded bytes are packed little-endian, 4 per word; a full word is written at message_addr + 4*n, n = 0,1,2,...
REQ-017 A final partial word is written with unused upper bytes = 0x00.
REQ-018 If rle_size is odd, the trailing byte is ignored.
REQ-019 FSM states: IDLE, READ_REQ, READ_WAIT, EXPAND, WRITE, FLUSH, DONE.
REQ-020 IDLE/DONE --start--> READ_REQ (or FLUSH if rle_size < 2); latch addresses/size, clear message_size, deassert done.
REQ-021 READ_REQ: drive read address, then READ_WAIT; READ_WAIT: capture word, then EXPAND.
REQ-022 EXPAND: emit one decoded byte per cycle; output word full -> WRITE, then resume EXPAND; stream word exhausted -> READ_REQ; all pairs consumed -> FLUSH.
REQ-023 A pair may straddle words only when rle_addr is not pair-aligned in memory; pairs never straddle words because rle_addr is word aligned and pairs are 2 bytes.
REQ-024 FLUSH: write partial word if at least 1 byte is pending, else no write; then DONE.
REQ-025 DONE: done = 1 and message_size holds until the next accepted start.
REQ-026 At most one memory access per cycle; port_A_we = 1 only in WRITE or in FLUSH with pending bytes.
REQ-027 start while busy is ignored.
REQ-028 message_size is a 32-bit count of bytes, incremented per emitted byte; no wrap required (maximum 255*rle_size/2).

Reset
REQ-029 On reset: state IDLE; done=0, message_size=0, port_A_we=0, port_A_addr=0, port_A_data_in=0; all internal counters and buffers cleared.
REQ-030 Reset mid-operation aborts immediately; no further memory writes occur.

Structure
REQ-031 Package rld_pkg holds: FSM state enum, BYTES_PER_WORD=4, ADDR_W=16, COUNT_W=8.
REQ-032 One sub-module, rld_word_packer: accepts a byte strobe, assembles little-endian words, flags full, and supports flush/clear.

Verification
REQ-033 Stream 0x42024103 (rle_size 4) -> writes 0x42414141 then 0x00000042; message_size=5; done=1.
REQ-034 rle_size=0 -> done within 3 cycles; message_size=0; port_A_we never asserted.
REQ-035 Pairs (00,41),(02,43) (word 0x43024100) -> single write 0x00004343; message_size=2.
REQ-036 Pair (FF,5A) -> 64 writes; first 63 words = 0x5A5A5A5A, last word = 0x005A5A5A; message_size=255.
REQ-037 Reset asserted during EXPAND -> all outputs 0 asynchronously; no write afterward; a fresh start then decodes correctly.
REQ-038 Round trip: 39-byte frame encoded by rle to 78 bytes at 0xC8 -> rld output matches original 39 bytes; message_size=39.

Source files
------------

// File: rtl/rld_pkg.sv
// Shared types and constants for the run-length decoder.
// Pure declarations, no timing of their own.
// Not applicable: no handshakes live here.
package rld_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_W         = 16;
    localparam int COUNT_W        = 8;

    typedef enum logic [2:0] {
        IDLE,
        READ_REQ,
        READ_WAIT,
        EXPAND,
        WRITE,
        FLUSH,
        DONE
    } state_t;

    // Memory is word organised; byte offsets inside a word are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/rld_word_packer.sv
// Assembles decoded bytes little-endian into a 32-bit word.
// One byte accepted per strobe; word_nxt shows the word including this cycle's byte.
// No backpressure: owner must clear before a fifth byte arrives.
module rld_word_packer
    import rld_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic [31:0] word_dat,
    output logic [31:0] word_nxt,
    output logic [2:0]  fill,
    output logic        full
);

    // The strobe that delivers the fourth byte completes the word.
    assign full = byte_vld && (fill == 3'(BYTES_PER_WORD - 1));

    // Insert the incoming byte at the current fill position.
    always_comb begin
        word_nxt = word_dat;
        if (byte_vld && !fill[2]) begin
            case (fill[1:0])
                2'd0:    word_nxt[7:0]   = byte_dat;
                2'd1:    word_nxt[15:8]  = byte_dat;
                2'd2:    word_nxt[23:16] = byte_dat;
                default: word_nxt[31:24] = byte_dat;
            endcase
        end
    end

    // Word and fill count; clearing zeroes unused upper bytes for partial words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_dat <= '0;
            fill     <= '0;
        end else if (clear) begin
            word_dat <= '0;
            fill     <= '0;
        end else if (byte_vld && !fill[2]) begin
            word_dat <= word_nxt;
            fill     <= fill + 3'd1;
        end
    end

endmodule

// File: rtl/rld.sv
// Run-length decoder: (count, symbol) byte pairs in memory -> expanded bytes in memory.
// Two cycles per stream word fetch, one per output byte, one per word write.
// No backpressure: the single memory port is assumed always ready.
module rld
    import rld_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] rle_addr,
    input  logic [31:0] rle_size,
    input  logic [31:0] message_addr,
    output logic [31:0] message_size,
    output logic        done,
    output logic        port_A_clk,
    output logic [15:0] port_A_addr,
    output logic        port_A_we,
    output logic [31:0] port_A_data_in,
    input  logic [31:0] port_A_data_out
);

    state_t              state;
    logic [31:0]         rd_addr;
    logic [31:0]         wr_addr;
    logic [30:0]         pairs_left;
    logic [31:8]         word_buf;    // byte 0 goes straight into rem at capture
    logic                pair_sel;    // 0: pair in bytes 0/1, 1: pair in bytes 2/3
    logic [COUNT_W-1:0]  rem;
    logic [31:0]         rd_addr_nxt;

    logic                start_ok;
    logic                emit;
    logic [7:0]          sym;
    logic                pk_clear;
    logic [31:0]         pk_word;
    logic [31:0]         pk_word_nxt;
    logic [2:0]          pk_fill;
    logic                pk_full;

    assign port_A_clk  = clk;
    assign start_ok    = start && (state == IDLE || state == DONE);
    assign emit        = (state == EXPAND) && (rem != '0);
    assign sym         = pair_sel ? word_buf[31:24] : word_buf[15:8];
    assign pk_clear    = start_ok || (state == WRITE) || (state == FLUSH);
    assign rd_addr_nxt = rd_addr + 32'(BYTES_PER_WORD);

    rld_word_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (pk_clear),
        .byte_vld (emit),
        .byte_dat (sym),
        .word_dat (pk_word),
        .word_nxt (pk_word_nxt),
        .fill     (pk_fill),
        .full     (pk_full)
    );

    // Control FSM; memory port outputs are registered on entry to the state that uses them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            rd_addr        <= '0;
            wr_addr        <= '0;
            pairs_left     <= '0;
            word_buf       <= '0;
            pair_sel       <= 1'b0;
            rem            <= '0;
            message_size   <= '0;
            done           <= 1'b0;
            port_A_addr    <= '0;
            port_A_we      <= 1'b0;
            port_A_data_in <= '0;
        end else begin
            port_A_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        rd_addr      <= word_align(rle_addr);
                        wr_addr      <= word_align(message_addr);
                        pairs_left   <= rle_size[31:1];
                        message_size <= '0;
                        done         <= 1'b0;
                        pair_sel     <= 1'b0;
                        rem          <= '0;
                        if (rle_size < 32'd2) begin
                            state <= FLUSH;
                        end else begin
                            state       <= READ_REQ;
                            port_A_addr <= word_align(rle_addr) & 32'h0000_FFFF;
                        end
                    end
                end
                READ_REQ: begin
                    state <= READ_WAIT;
                end
                READ_WAIT: begin
                    word_buf <= port_A_data_out[31:8];
                    rem      <= port_A_data_out[7:0];
                    pair_sel <= 1'b0;
                    state    <= EXPAND;
                end
                EXPAND: begin
                    if (rem != '0) begin
                        rem          <= rem - 1'b1;
                        message_size <= message_size + 32'd1;
                        if (pk_full) begin
                            state          <= WRITE;
                            port_A_we      <= 1'b1;
                            port_A_addr    <= wr_addr[ADDR_W-1:0];
                            port_A_data_in <= pk_word_nxt;
                        end
                    end else if (pairs_left == 31'd1) begin
                        // Last pair finished: a write is only issued if bytes are pending.
                        pairs_left     <= '0;
                        state          <= FLUSH;
                        port_A_we      <= (pk_fill != 3'd0);
                        port_A_addr    <= wr_addr[ADDR_W-1:0];
                        port_A_data_in <= pk_word;
                    end else begin
                        pairs_left <= pairs_left - 31'd1;
                        if (pair_sel) begin
                            rd_addr     <= rd_addr_nxt;
                            port_A_addr <= rd_addr_nxt[ADDR_W-1:0];
                            state       <= READ_REQ;
                        end else begin
                            pair_sel <= 1'b1;
                            rem      <= word_buf[23:16];
                        end
                    end
                end
                WRITE: begin
                    wr_addr <= wr_addr + 32'(BYTES_PER_WORD);
                    state   <= EXPAND;
                end
                FLUSH: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rld.sv
module tb_rld;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] rle_addr;
    logic [31:0] rle_size;
    logic [31:0] message_addr;
    logic [31:0] message_size;
    logic        done;
    logic        port_A_clk;
    logic [15:0] port_A_addr;
    logic        port_A_we;
    logic [31:0] port_A_data_in;
    logic [31:0] port_A_data_out;

    rld dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .rle_addr        (rle_addr),
        .rle_size        (rle_size),
        .message_addr    (message_addr),
        .message_size    (message_size),
        .done            (done),
        .port_A_clk      (port_A_clk),
        .port_A_addr     (port_A_addr),
        .port_A_we       (port_A_we),
        .port_A_data_in  (port_A_data_in),
        .port_A_data_out (port_A_data_out)
    );

    always #5 clk = ~clk;

    // Word memory with one-cycle read latency, plus a bench load port.
    logic [31:0] mem [0:16383];
    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = '0;
    logic [31:0] ld_dat = '0;

    always @(posedge clk) begin
        if (port_A_we)
            mem[port_A_addr[15:2]] <= port_A_data_in;
        else if (ld_en)
            mem[ld_addr[15:2]] <= ld_dat;
        port_A_data_out <= mem[port_A_addr[15:2]];
    end

    // Log of every write the decoder performs.
    logic [15:0] log_a [0:127];
    logic [31:0] log_d [0:127];
    int          log_n = 0;
    logic        log_clr = 1'b0;

    always @(posedge clk) begin
        if (log_clr) begin
            log_n <= 0;
        end else if (port_A_we) begin
            if (log_n < 128) begin
                log_a[log_n] <= port_A_addr;
                log_d[log_n] <= port_A_data_in;
            end
            log_n <= log_n + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    logic [7:0] sb    [0:127];   // compressed stream bytes
    logic [7:0] exp_b [0:511];   // expected decoded bytes
    int         exp_n;
    logic [7:0] frame [0:38];

    typedef struct {
        logic [31:0] ra;
        logic [31:0] rs;
        logic [31:0] ma;
        logic [31:0] w0;
        logic [31:0] w1;
        int          exp_sz;
        int          exp_nwr;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        int          max_cyc;
    } vec_t;

    vec_t vecs [0:8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic load_words(input logic [31:0] base, input int nw);
        for (int i = 0; i < nw; i++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = 16'(base + 32'(4 * i));
            ld_dat  = {sb[4*i+3], sb[4*i+2], sb[4*i+1], sb[4*i]};
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic run_dec(input logic [31:0] ra, input logic [31:0] rs, input logic [31:0] ma,
                           output int cyc);
        @(negedge clk);
        log_clr = 1'b1;
        @(negedge clk);
        log_clr      = 1'b0;
        rle_addr     = ra;
        rle_size     = rs;
        message_addr = ma;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: done=0 after %0d cycles, required 1", cyc);
        end
    endtask

    // Reference expansion of the pairs held in sb.
    task automatic model_expand(input logic [31:0] rs);
        exp_n = 0;
        for (int p = 0; p < int'(rs / 2); p++)
            for (int c = 0; c < int'(sb[2*p]); c++) begin
                exp_b[exp_n] = sb[2*p+1];
                exp_n++;
            end
    endtask

    // Every logged write against the expected byte list and address sequence.
    task automatic check_writes(input logic [31:0] ma);
        int          nwr;
        logic [31:0] d;
        logic [31:0] a;
        nwr = (exp_n + 3) / 4;
        check("write_count_model", 32'(log_n), 32'(nwr));
        for (int k = 0; k < nwr && k < log_n; k++) begin
            d = '0;
            for (int j = 0; j < 4; j++)
                if (4*k + j < exp_n) d[8*j +: 8] = exp_b[4*k + j];
            a = (ma & 32'hFFFF_FFFC) + 32'(4 * k);
            check($sformatf("wr_addr[%0d]", k), {16'h0, log_a[k]}, {16'h0, a[15:0]});
            check($sformatf("wr_data[%0d]", k), log_d[k], d);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          n0;
        int          enc_n;
        int          w;
        logic [31:0] ww;

        vecs[0] = '{32'h0100, 4, 32'h0800, 32'h42024103, 32'h0,        5, 2,  32'h42414141, 32'h00000042, 100};
        vecs[1] = '{32'h0110, 0, 32'h0810, 32'h0,        32'h0,        0, 0,  32'h0,        32'h0,        3};
        vecs[2] = '{32'h0122, 4, 32'h0823, 32'h43024100, 32'h0,        2, 1,  32'h00004343, 32'h00004343, 100};
        vecs[3] = '{32'h0130, 2, 32'h0900, 32'h00005AFF, 32'h0,      255, 64, 32'h5A5A5A5A, 32'h005A5A5A, 2000};
        vecs[4] = '{32'h0140, 3, 32'h0A00, 32'h77014402, 32'h0,        2, 1,  32'h00004444, 32'h00004444, 100};
        vecs[5] = '{32'h0150, 2, 32'h0A40, 32'h00003104, 32'h0,        4, 1,  32'h31313131, 32'h31313131, 100};
        vecs[6] = '{32'h0160, 8, 32'h0A80, 32'h62016102, 32'h64036301, 7, 2,  32'h63626161, 32'h00646464, 100};
        vecs[7] = '{32'h0170, 4, 32'h0AC0, 32'h55003300, 32'h0,        0, 0,  32'h0,        32'h0,        100};
        vecs[8] = '{32'h0180, 1, 32'h0B00, 32'h00000005, 32'h0,        0, 0,  32'h0,        32'h0,        3};

        reset        = 1'b1;
        start        = 1'b0;
        rle_addr     = '0;
        rle_size     = '0;
        message_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_done",     {31'h0, done},      32'h0);
        check("rst_msg_size", message_size,       32'h0);
        check("rst_we",       {31'h0, port_A_we}, 32'h0);
        check("rst_addr",     {16'h0, port_A_addr}, 32'h0);
        check("rst_data_in",  port_A_data_in,     32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            for (int b = 0; b < 4; b++) begin
                ww = vecs[i].w0; sb[b]   = ww[8*b +: 8];
                ww = vecs[i].w1; sb[b+4] = ww[8*b +: 8];
            end
            w = int'((vecs[i].rs + 3) / 4);
            load_words(vecs[i].ra & 32'hFFFF_FFFC, w);
            run_dec(vecs[i].ra, vecs[i].rs, vecs[i].ma, cyc);
            check($sformatf("v%0d_done", i),     {31'h0, done},   32'h1);
            check($sformatf("v%0d_msg_size", i), message_size,    32'(vecs[i].exp_sz));
            check($sformatf("v%0d_nwrites", i),  32'(log_n),      32'(vecs[i].exp_nwr));
            check($sformatf("v%0d_cyc_ok", i),   {31'h0, cyc <= vecs[i].max_cyc}, 32'h1);
            if (vecs[i].exp_nwr > 0 && log_n > 0) begin
                check($sformatf("v%0d_first", i), log_d[0],       vecs[i].exp_first);
                check($sformatf("v%0d_last", i),  log_d[log_n-1], vecs[i].exp_last);
            end
            model_expand(vecs[i].rs);
            check_writes(vecs[i].ma);
        end

        // Reset in the middle of a long expansion.
        sb[0] = 8'hFF; sb[1] = 8'h5A; sb[2] = 8'h00; sb[3] = 8'h00;
        load_words(32'h0300, 1);
        @(negedge clk);
        log_clr = 1'b1;
        @(negedge clk);
        log_clr      = 1'b0;
        rle_addr     = 32'h0300;
        rle_size     = 32'd2;
        message_addr = 32'h0600;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (log_n < 5 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_reached_writes", {31'h0, log_n >= 5}, 32'h1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_done",     {31'h0, done},        32'h0);
        check("mid_rst_msg_size", message_size,         32'h0);
        check("mid_rst_we",       {31'h0, port_A_we},   32'h0);
        check("mid_rst_addr",     {16'h0, port_A_addr}, 32'h0);
        check("mid_rst_data_in",  port_A_data_in,       32'h0);
        n0 = log_n;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_no_write_after", 32'(log_n), 32'(n0));
        check("mid_idle_done",      {31'h0, done}, 32'h0);

        sb[0] = 8'h03; sb[1] = 8'h41; sb[2] = 8'h02; sb[3] = 8'h42;
        load_words(32'h0310, 1);
        run_dec(32'h0310, 32'd4, 32'h0700, cyc);
        check("post_rst_msg_size", message_size, 32'd5);
        check("post_rst_nwrites",  32'(log_n),   32'd2);
        exp_n = 5;
        exp_b[0] = 8'h41; exp_b[1] = 8'h41; exp_b[2] = 8'h41; exp_b[3] = 8'h42; exp_b[4] = 8'h42;
        check_writes(32'h0700);

        // Round trip: a 39-byte frame with no adjacent repeats, run-length encoded here.
        for (int i = 0; i < 39; i++) frame[i] = 8'((i * 7 + 3) & 8'hFF);
        enc_n = 0;
        for (int i = 0; i < 39; ) begin
            int run;
            run = 1;
            while (i + run < 39 && frame[i+run] == frame[i] && run < 255) run++;
            sb[enc_n]   = 8'(run);
            sb[enc_n+1] = frame[i];
            enc_n += 2;
            i += run;
        end
        for (int i = enc_n; i < enc_n + 4; i++) sb[i] = 8'h00;
        load_words(32'h00C8, (enc_n + 3) / 4);
        run_dec(32'h00C8, 32'(enc_n), 32'h0400, cyc);
        check("rt_msg_size", message_size, 32'd39);
        check("rt_nwrites",  32'(log_n),   32'd10);
        exp_n = 39;
        for (int i = 0; i < 39; i++) exp_b[i] = frame[i];
        check_writes(32'h0400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
